// File: rtl/vote_pkg.sv
// Shared constants, types and helper functions for the k-of-N voter and its persistence counters.
package vote_pkg;

  localparam int MAX_N = 16;

  // Restart: counter returns to zero on its terminal cycle (filter re-arms).
  // Saturate: counter parks at its limit while the mismatch persists (fault tracking).
  typedef enum logic {
    PERSIST_RESTART  = 1'b0,
    PERSIST_SATURATE = 1'b1
  } persist_mode_e;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int ctr_width(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

  // Counts set bits among the lowest w bits of x.
  function automatic int unsigned popcount(input logic [MAX_N-1:0] x, input int w);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < w) c += 32'(x[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/vote_persist.sv
// Saturating consecutive-mismatch counter: o_term pulses on the cycle the run of
// mismatches reaches LIM; any matching cycle (or i_clr) returns the count to zero.
module vote_persist
  import vote_pkg::*;
#(
  parameter int            LIM  = 4,
  parameter persist_mode_e MODE = PERSIST_RESTART
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_mismatch,
  output logic o_term
);

  localparam int             W    = ctr_width(LIM);
  localparam logic [W-1:0]   LAST = W'(LIM - 1);
  localparam logic [W-1:0]   FULL = W'(LIM);

  if (LIM < 1) begin : g_bad_lim
    $error("vote_persist: LIM must be >= 1");
  end

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count >= LAST);
  assign o_term    = i_en && !i_clr && i_mismatch && w_at_last;

  // NOTE: asynchronous active-low reset sits in the sensitivity list so state
  // clears the instant rst_n falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for every sequential update, so all
      // registers sample pre-edge values regardless of statement order.
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      if (!i_mismatch) begin
        r_count <= '0;
      end else if (w_at_last) begin
        r_count <= (MODE == PERSIST_RESTART) ? '0 : FULL;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vote_filter.sv
// Parametrised k-of-N voter with registered inputs, a persistence-filtered output
// and sticky per-channel disagreement fault flags.
module vote_filter
  import vote_pkg::*;
#(
  parameter int N         = 3,
  parameter int K         = 2,
  parameter int CONFIRM   = 4,
  parameter int FAULT_LIM = 8,
  localparam int CW       = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [N-1:0]  v,
  output logic [CW-1:0] cnt,
  output logic          raw,
  output logic          out,
  output logic [N-1:0]  fault
);

  if (N < 1 || N > MAX_N || K < 1 || K > N || CONFIRM < 1 || FAULT_LIM < 1) begin : g_bad_params
    $error("vote_filter: parameter out of range (1<=N<=16, 1<=K<=N, CONFIRM>=1, FAULT_LIM>=1)");
  end

  logic [N-1:0]  r_v_q;
  logic          r_raw;
  logic          r_out;
  logic [N-1:0]  r_fault;
  logic [CW-1:0] w_cnt;
  logic          w_dec;
  logic          w_out_term;
  logic [N-1:0]  w_fault_term;

  assign w_cnt = CW'(popcount(MAX_N'(r_v_q), N));
  assign w_dec = (int'(w_cnt) >= K);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_q <= '0;
      r_raw <= 1'b0;
      r_out <= 1'b0;
    end else if (en) begin
      r_v_q <= v;
      r_raw <= w_dec;
      if (w_out_term) r_out <= r_raw;
    end
  end

  // Output changes only after raw has disagreed with it for CONFIRM straight cycles.
  vote_persist #(
    .LIM  (CONFIRM),
    .MODE (PERSIST_RESTART)
  ) u_confirm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_clr      (1'b0),
    .i_mismatch (r_raw != r_out),
    .o_term     (w_out_term)
  );

  for (genvar i = 0; i < N; i++) begin : g_fault
    vote_persist #(
      .LIM  (FAULT_LIM),
      .MODE (PERSIST_SATURATE)
    ) u_fc (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (en),
      .i_clr      (clr),
      .i_mismatch (r_v_q[i] != w_dec),
      .o_term     (w_fault_term[i])
    );
  end

  // clr wins over a simultaneous set and acts even while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= '0;
    end else if (clr) begin
      r_fault <= '0;
    end else begin
      r_fault <= r_fault | w_fault_term;
    end
  end

  assign cnt   = w_cnt;
  assign raw   = r_raw;
  assign out   = r_out;
  assign fault = r_fault;

endmodule

// File: tb/tb_vote_filter.sv
// Scoreboard bench for vote_filter: a 3-input 2-of-3 build and a 5-input unanimity build.
module tb_vote_filter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [2:0] v_a;
  logic [4:0] v_b;
  logic [1:0] cnt_a;
  logic       raw_a, out_a;
  logic [2:0] fault_a;
  logic [2:0] cnt_b;
  logic       raw_b, out_b;
  logic [4:0] fault_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string name;
    int    dut;
    int    cnt;
    int    raw;
    int    out;
    int    fault;
    int    sc;
    int    fc0;   // -1: not compared
  } exp_t;

  exp_t sb[$];

  vote_filter #(.N(3), .K(2), .CONFIRM(4), .FAULT_LIM(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .v(v_a),
    .cnt(cnt_a), .raw(raw_a), .out(out_a), .fault(fault_a)
  );

  vote_filter #(.N(5), .K(5), .CONFIRM(4), .FAULT_LIM(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .v(v_b),
    .cnt(cnt_b), .raw(raw_b), .out(out_b), .fault(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    int a_cnt, a_raw, a_out, a_fault, a_sc, a_fc0;
    if (e.dut == 0) begin
      a_cnt   = int'(cnt_a);
      a_raw   = int'(raw_a);
      a_out   = int'(out_a);
      a_fault = int'(fault_a);
      a_sc    = int'(u_a.u_confirm.r_count);
      a_fc0   = int'(u_a.g_fault[0].u_fc.r_count);
    end else begin
      a_cnt   = int'(cnt_b);
      a_raw   = int'(raw_b);
      a_out   = int'(out_b);
      a_fault = int'(fault_b);
      a_sc    = int'(u_b.u_confirm.r_count);
      a_fc0   = int'(u_b.g_fault[0].u_fc.r_count);
    end
    checks++;
    if (a_cnt != e.cnt || a_raw != e.raw || a_out != e.out || a_fault != e.fault ||
        a_sc != e.sc || (e.fc0 >= 0 && a_fc0 != e.fc0)) begin
      errors++;
      $display("FAIL %s (dut%0d): got cnt=%0d raw=%0d out=%0d fault=%0h sc=%0d fc0=%0d, expected cnt=%0d raw=%0d out=%0d fault=%0h sc=%0d fc0=%0d",
               e.name, e.dut, a_cnt, a_raw, a_out, a_fault, a_sc, a_fc0,
               e.cnt, e.raw, e.out, e.fault, e.sc, e.fc0);
    end
  endtask

  // Monitor: one expected entry is consumed at each falling edge it was queued for.
  always @(negedge clk) begin
    if (sb.size() > 0) check(sb.pop_front());
  end

  task automatic push(input string nm, input int d, input int c, input int r, input int o,
                      input int f, input int s, input int fc0);
    exp_t e;
    e.name = nm; e.dut = d; e.cnt = c; e.raw = r; e.out = o;
    e.fault = f; e.sc = s; e.fc0 = fc0;
    sb.push_back(e);
  endtask

  // Queue the expectation for the coming rising edge, then move past the falling edge.
  task automatic cyc(input string nm, input int d, input int c, input int r, input int o,
                     input int f, input int s, input int fc0);
    push(nm, d, c, r, o, f, s, fc0);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] toggles [5];
    int sc_tab [7];
    toggles = '{3'b000, 3'b111, 3'b100, 3'b010, 3'b101};
    sc_tab  = '{0, 0, 1, 2, 3, 0, 0};

    rst_n = 1'b0; en = 1'b1; clr = 1'b0; v_a = '0; v_b = '0;
    #1;
    cyc("reset_state", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Latency run interrupted by an asynchronous reset mid-confirmation.
    v_a = 3'b011;
    cyc("lat_e1", 0, 2, 0, 0, 0, 0, 0);
    cyc("lat_e2", 0, 2, 1, 0, 0, 0, 0);
    cyc("lat_e3", 0, 2, 1, 0, 0, 1, 0);
    cyc("lat_e4", 0, 2, 1, 0, 0, 2, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push("async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++)
      cyc($sformatf("restart_e%0d", e), 0, 2, (e >= 2) ? 1 : 0, (e >= 6) ? 1 : 0, 0,
          (e >= 3 && e <= 5) ? e - 2 : 0, 0);

    // Glitch: three cycles of majority then none; out must never move.
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      v_a = (e <= 3) ? 3'b011 : 3'b000;
      cyc($sformatf("glitch_e%0d", e), 0, (e <= 3) ? 2 : 0, (e >= 2 && e <= 4) ? 1 : 0, 0, 0,
          sc_tab[e-1], 0);
    end

    // Fault on channel 0 sets at edge 9 and stays after the channel recovers.
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      v_a = (e <= 9) ? 3'b001 : 3'b000;
      cyc($sformatf("fault_e%0d", e), 0, (e <= 9) ? 1 : 0, 0, 0, (e >= 9) ? 1 : 0, 0,
          (e == 1 || e == 11) ? 0 : ((e <= 8) ? e - 1 : -1));
    end
    en = 1'b0; clr = 1'b1;
    cyc("clr_while_en0", 0, 0, 0, 0, 0, 0, 0);
    en = 1'b1; clr = 1'b0;

    // clr on the very cycle the fault would set.
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      v_a = 3'b001;
      clr = (e == 9);
      cyc($sformatf("clr_race_e%0d", e), 0, 1, 0, 0, 0, 0, (e == 9) ? 0 : ((e == 10) ? 1 : e - 1));
    end
    clr = 1'b0;

    // en=0 freezes a half-finished confirmation; it completes after en returns.
    do_reset();
    v_a = 3'b011;
    cyc("frz_e1", 0, 2, 0, 0, 0, 0, 0);
    cyc("frz_e2", 0, 2, 1, 0, 0, 0, 0);
    cyc("frz_e3", 0, 2, 1, 0, 0, 1, 0);
    cyc("frz_e4", 0, 2, 1, 0, 0, 2, 0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      v_a = toggles[k];
      cyc($sformatf("frozen_%0d", k), 0, 2, 1, 0, 0, 2, 0);
    end
    en = 1'b1; v_a = 3'b011;
    cyc("thaw_e1", 0, 2, 1, 0, 0, 3, 0);
    cyc("thaw_e2", 0, 2, 1, 1, 0, 0, 0);

    // Unanimity build: four of five never votes, five of five confirms after 2+CONFIRM edges.
    do_reset();
    v_a = 3'b000;
    for (int e = 1; e <= 9; e++) begin
      v_b = (e <= 3) ? 5'b11110 : 5'b11111;
      cyc($sformatf("k5_e%0d", e), 1, (e <= 3) ? 4 : 5, (e >= 5) ? 1 : 0, (e >= 9) ? 1 : 0, 0,
          (e >= 6 && e <= 8) ? e - 5 : 0, -1);
    end

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vote_filter.md
Name: vote_filter

Overview:
- Parametrised N-input k-of-N voter; successor to the fixed three-input gate-level voting cell.
- Registers the channel inputs and computes a threshold vote.
- Filters the vote through a persistence counter, so the output only changes after the new decision is stable for CONFIRM cycles.
- Tracks each channel's disagreement with the vote and raises a sticky per-channel fault flag.
- Sits between redundant sensor/logic channels and downstream control.

Parameters:
- N, 3, number of voted channels (1..16).
- K, 2, votes required to assert the decision (1 <= K <= N); K=N gives unanimity.
- CONFIRM, 4, consecutive cycles a new decision must persist before out changes (>= 1).
- FAULT_LIM, 8, consecutive disagreeing cycles before a channel's fault flag sets (>= 1).
- CW, derived, $clog2(N+1), width of cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  pipeline/counter enable; 0 freezes all state.
- clr  input  1  synchronous clear of fault flags and fault counters.
- v  input  N  channel inputs.
- cnt  output  CW  popcount of registered inputs.
- raw  output  1  registered unfiltered decision.
- out  output  1  filtered decision.
- fault  output  N  sticky per-channel fault flags.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-confirmation): v_q=0, cnt=0, raw=0, out=0, stability counter sc=0, all fault counters fc[i]=0, fault=0.
- Stage 1 (en=1): v_q <= v; cnt = popcount(v_q); dec = (cnt >= K), combinational.
- Stage 2 (en=1): raw <= dec.
- Filter (en=1):
  - raw == out: sc <= 0.
  - raw != out and sc == CONFIRM-1: out <= raw, sc <= 0.
  - Otherwise: sc <= sc+1.
- Latency: v stable before edge 1 -> v_q at edge 1, raw at edge 2, out at edge 2+CONFIRM. With CONFIRM=1, out lags raw by one cycle.
- Glitch rejection: any cycle with raw == out before the count completes resets sc. Partial confirmations never accumulate.
- Fault (en=1), per channel i:
  - v_q[i] != dec and fc[i] == FAULT_LIM-1: fault[i] <= 1, fc[i] saturates.
  - v_q[i] != dec otherwise: fc[i] <= fc[i]+1.
  - v_q[i] == dec: fc[i] <= 0.
  - fault[i] stays set until clr or reset.
- clr: clears fault and all fc in the same cycle. It has priority over a simultaneous set and acts regardless of en.
- en=0: v_q, raw, out, sc and fc all hold; cnt and dec still reflect the held v_q.
- Elaboration check: violation of K, N, CONFIRM or FAULT_LIM limits is an elaboration-time error.
- Width rules:
  - sc width: $clog2(CONFIRM+1).
  - fc width: $clog2(FAULT_LIM+1).
  - Neither counter ever wraps.

Decomposition:
- Package vote_pkg holds:
  - popcount function, parametrised by width.
  - CW / counter-width helper functions.
  - MAX_N=16 constant.
- One sub-module: vote_persist, a saturating "consecutive mismatch" counter with terminal pulse and synchronous clear.
  - Instantiated once for the out filter (CONFIRM).
  - Instantiated N times via generate for fault tracking (FAULT_LIM).

Test Plan:
1. N=3, K=2, CONFIRM=4; drive v=3'b011 from cycle 0 -> cnt=2 after edge 1, raw=1 after edge 2, out=1 after edge 6, not earlier.
2. Glitch: v=3'b011 for 3 cycles, then 3'b000 -> raw pulses for 3 cycles, out stays 0, sc returns to 0.
3. Fault: FAULT_LIM=8, v=3'b001 held -> dec=0; fault=3'b001 after edge 9, other bits 0. Then v=3'b000 -> fault stays 3'b001 (sticky).
4. clr asserted in the cycle fault[0] would set -> fault remains 3'b000, fc[0]=0.
5. Reset mid-confirmation: rst_n=0 asynchronously after edge 4 of test 1 -> all outputs 0 immediately. After release, the 6-edge latency restarts from scratch.
6. en=0 with v toggling for 5 cycles, then N=5, K=5 build with v=5'b11110 -> en=0 leaves state frozen; in the K=5 build, raw=0 and out=0, and v=5'b11111 gives out=1 after edge 2+CONFIRM.
